// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential, branch, jump, JR, return and exception next-PC selection with stall.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_seq_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h80),
    parameter int              BYTE_ADDR = 1,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero_flag,
    input  logic [31:0]     extended,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            link,
    input  logic            ret,
    input  logic            exc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    localparam logic [PC_W-1:0] INC = (BYTE_ADDR != 0) ? PC_W'(4) : PC_W'(1);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ext_s, off, br_tgt, jmp_tgt, ret_tgt;

    assign pc      = pc_q;
    assign pc_plus = pc_q + INC;

    always_comb begin
        ext_s   = PC_W'($signed(extended));
        off     = (BYTE_ADDR != 0) ? (ext_s << 2) : ext_s;
        br_tgt  = pc_plus + off;
        jmp_tgt = pc_plus;
        if (BYTE_ADDR != 0) begin
            jmp_tgt[27:0] = {jump_target, 2'b00};
        end else begin
            jmp_tgt[25:0] = jump_target;
        end
    end

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            empty_w, full_w;

    assign empty_w   = (cnt_q == '0);
    assign full_w    = (cnt_q == CW'(RAS_DEPTH));
    assign ras_empty = empty_w;
    assign ras_full  = full_w;
    assign ras_err   = err_q;
    assign ret_tgt   = empty_w ? jr_target : ras_q[top_q];

    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (!exc && !stall) begin
            if (link && ret) begin
                // Return consumes the top, the call's link address takes its slot.
                ras_d[top_q] = pc_plus;
                if (empty_w) begin
                    cnt_d = CW'(1);
                    err_d = 1'b1;
                end
            end else if (link) begin
                top_d        = top_q + PW'(1);
                ras_d[top_d] = pc_plus;
                if (full_w) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (ret) begin
                if (empty_w) begin
                    err_d = 1'b1;
                end else begin
                    top_d = top_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry contents need no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end
`else
    logic unused_link;

    assign unused_link = link;
    assign ret_tgt     = jr_target;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign ras_err     = 1'b0;
`endif

    always_comb begin
        if (exc) begin
            pc_d = EXC_VEC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            pc_d = ret_tgt;
        end else if (jr) begin
            pc_d = jr_target;
        end else if (jump) begin
            pc_d = jmp_tgt;
        end else if (branch && zero_flag) begin
            pc_d = br_tgt;
        end else begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Randomized self-checking bench for pc_seq_unit, with byte- and word-addressed instances
// compared against a queue-based reference model.
module tb_pc_seq_unit;

    localparam int D = 4;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, branch, zero_flag, jump, jr, link, ret, exc;
    logic [31:0] extended, jr_target;
    logic [25:0] jump_target;
    logic [31:0] pc_b, pcp_b, pc_w, pcp_w;
    logic        e_b, f_b, r_b, e_w, f_w, r_w;

    always #5 clk = ~clk;

    pc_seq_unit #(.PC_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .BYTE_ADDR(1), .RAS_DEPTH(D)) u_dut_b (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero_flag(zero_flag),
        .extended(extended), .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .link(link), .ret(ret), .exc(exc), .pc(pc_b), .pc_plus(pcp_b),
        .ras_empty(e_b), .ras_full(f_b), .ras_err(r_b));

    pc_seq_unit #(.PC_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .BYTE_ADDR(0), .RAS_DEPTH(D)) u_dut_w (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero_flag(zero_flag),
        .extended(extended), .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .link(link), .ret(ret), .exc(exc), .pc(pc_w), .pc_plus(pcp_w),
        .ras_empty(e_w), .ras_full(f_w), .ras_err(r_w));

    wire [66:0] obs_b = {pc_b, pcp_b, e_b, f_b, r_b};
    wire [66:0] obs_w = {pc_w, pcp_w, e_w, f_w, r_w};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: index 0 = byte-addressed instance, 1 = word-addressed instance.
    logic [31:0] m_pc [2];
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];
    bit          m_err [2];

    function automatic logic [66:0] exp_vec(int i);
        int          sz;
        logic [31:0] inc;
        sz  = (i == 0) ? mq0.size() : mq1.size();
        inc = (i == 0) ? 32'd4 : 32'd1;
        if (RAS_ON) return {m_pc[i], m_pc[i] + inc, sz == 0, sz == D, m_err[i]};
        return {m_pc[i], m_pc[i] + inc, 3'b100};
    endfunction

    task automatic model_reset();
        m_pc[0] = 32'h0;  m_pc[1] = 32'h0;
        m_err[0] = 1'b0;  m_err[1] = 1'b0;
        mq0.delete();     mq1.delete();
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] q [$];
            logic [31:0] inc, pp, off, tgt, jt;
            if (i == 0) q = mq0; else q = mq1;
            inc = (i == 0) ? 32'd4 : 32'd1;
            pp  = m_pc[i] + inc;
            off = (i == 0) ? (extended << 2) : extended;
            jt  = (i == 0) ? {pp[31:28], jump_target, 2'b00} : {pp[31:26], jump_target};
            if (exc) begin
                m_pc[i] = 32'h80;
            end else if (!stall) begin
                if (ret) begin
                    if (RAS_ON && q.size() > 0) tgt = q[q.size()-1];
                    else tgt = jr_target;
                end else if (jr)                  tgt = jr_target;
                else if (jump)                    tgt = jt;
                else if (branch && zero_flag)     tgt = pp + off;
                else                              tgt = pp;
                m_pc[i] = tgt;
                if (RAS_ON) begin
                    if (link && ret) begin
                        if (q.size() > 0) q[q.size()-1] = pp;
                        else begin q.push_back(pp); m_err[i] = 1'b1; end
                    end else if (link) begin
                        q.push_back(pp);
                        if (q.size() > D) begin void'(q.pop_front()); m_err[i] = 1'b1; end
                    end else if (ret) begin
                        if (q.size() > 0) void'(q.pop_back());
                        else m_err[i] = 1'b1;
                    end
                end
            end
            if (i == 0) mq0 = q; else mq1 = q;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch = 0; zero_flag = 0; jump = 0; jr = 0; link = 0; ret = 0; exc = 0;
        extended = 32'h0; jr_target = 32'h0; jump_target = 26'h0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        clear_inputs();
        jr = 1; jr_target = a;
        step();
        clear_inputs();
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        @(negedge clk);
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        #3;
        n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL reset_byte got=%h exp=%h", obs_b, exp_vec(0)); else n_pass++;
        n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL reset_word got=%h exp=%h", obs_w, exp_vec(1)); else n_pass++;
        @(negedge clk);
        reset = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++; if (pc_b !== 32'(k * 4)) $display("FAIL seq_byte_%0d got=%h exp=%h", k, pc_b, 32'(k * 4)); else n_pass++;
            n_checks++; if (pc_w !== 32'(k))     $display("FAIL seq_word_%0d got=%h exp=%h", k, pc_w, 32'(k));     else n_pass++;
            n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL seq_model_b got=%h exp=%h", obs_b, exp_vec(0)); else n_pass++;
        end
    endtask

    task automatic test_branch();
        logic [31:0] want [2];
        want[0] = 32'hFC; want[1] = 32'h104;
        for (int k = 0; k < 2; k++) begin
            set_pc(32'h100);
            branch = 1; zero_flag = (k == 0); extended = -32'sd2;
            step();
            n_checks++; if (pc_b !== want[k]) $display("FAIL branch_%0d got=%h exp=%h", k, pc_b, want[k]); else n_pass++;
            n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL branch_word_%0d got=%h exp=%h", k, obs_w, exp_vec(1)); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        set_pc(32'h40);
        link = 1; jump = 1; jump_target = 26'(32'h300 >> 2);
        step();
        clear_inputs();
        exc = 1; ret = 1; jump = 1; stall = 1; jr_target = 32'h500; jump_target = 26'h123;
        step();
        n_checks++; if (pc_b !== 32'h80) $display("FAIL prio_exc got=%h exp=%h", pc_b, 32'h80); else n_pass++;
        n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL prio_ras_b got=%h exp=%h", obs_b, exp_vec(0)); else n_pass++;
        n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL prio_ras_w got=%h exp=%h", obs_w, exp_vec(1)); else n_pass++;
        clear_inputs();
        stall = 1;
        step();
        n_checks++; if (pc_b !== 32'h80) $display("FAIL stall_hold got=%h exp=%h", pc_b, 32'h80); else n_pass++;
        n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL stall_word got=%h exp=%h", obs_w, exp_vec(1)); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_ras();
        apply_reset();
        set_pc(32'h10);
        for (int k = 0; k < 5; k++) begin
            link = 1; jump = 1; jump_target = 26'((32'h20 + 32'h10 * k) >> 2);
            step();
            n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL jal_b_%0d got=%h exp=%h", k, obs_b, exp_vec(0)); else n_pass++;
            n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL jal_w_%0d got=%h exp=%h", k, obs_w, exp_vec(1)); else n_pass++;
        end
`ifdef PC_SEQ_RAS_EN
        n_checks++; if ({f_b, r_b} !== 2'b11) $display("FAIL ras_full_err got=%b exp=11", {f_b, r_b}); else n_pass++;
`endif
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            ret = 1; jr_target = 32'h700;
            step();
            n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL ret_b_%0d got=%h exp=%h", k, obs_b, exp_vec(0)); else n_pass++;
            n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL ret_w_%0d got=%h exp=%h", k, obs_w, exp_vec(1)); else n_pass++;
`ifdef PC_SEQ_RAS_EN
            n_checks++; if (pc_b !== 32'h54 - 32'h10 * k) $display("FAIL ret_tgt_%0d got=%h exp=%h", k, pc_b, 32'h54 - 32'h10 * k); else n_pass++;
`endif
        end
        jr_target = 32'h900;
        step();
        n_checks++; if (pc_b !== 32'h900) $display("FAIL ret_empty got=%h exp=%h", pc_b, 32'h900); else n_pass++;
        n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL ret_empty_b got=%h exp=%h", obs_b, exp_vec(0)); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_wrap();
        apply_reset();
        set_pc(32'hFFFF_FFFC);
        step();
        n_checks++; if (pc_b !== 32'h0) $display("FAIL wrap_pc got=%h exp=%h", pc_b, 32'h0); else n_pass++;
        n_checks++; if (r_b !== 1'b0) $display("FAIL wrap_flag got=%b exp=0", r_b); else n_pass++;
        n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL wrap_word got=%h exp=%h", obs_w, exp_vec(1)); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 4) == 0);
            exc         = ($urandom_range(0, 19) == 0);
            ret         = ($urandom_range(0, 3) == 0);
            link        = ($urandom_range(0, 3) == 0);
            jr          = ($urandom_range(0, 5) == 0);
            jump        = ($urandom_range(0, 4) == 0);
            branch      = ($urandom_range(0, 2) == 0);
            zero_flag   = $urandom_range(0, 1);
            extended    = 32'($urandom_range(0, 255)) - 32'd128;
            jr_target   = $urandom;
            jump_target = 26'($urandom);
            step();
            n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL rand_b_%0d got=%h exp=%h", n, obs_b, exp_vec(0)); else n_pass++;
            n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL rand_w_%0d got=%h exp=%h", n, obs_w, exp_vec(1)); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        set_pc(32'h200);
        n_checks++; if (pc_b !== 32'h200) $display("FAIL pre_async got=%h exp=%h", pc_b, 32'h200); else n_pass++;
        stall = 1;
        #2;
        reset = 0;
        model_reset();
        #1;
        n_checks++; if (pc_b !== 32'h0) $display("FAIL async_reset got=%h exp=%h", pc_b, 32'h0); else n_pass++;
        n_checks++; if (obs_b !== exp_vec(0)) $display("FAIL async_b got=%h exp=%h", obs_b, exp_vec(0)); else n_pass++;
        n_checks++; if (obs_w !== exp_vec(1)) $display("FAIL async_w got=%h exp=%h", obs_w, exp_vec(1)); else n_pass++;
        #2;
        reset = 1;
        clear_inputs();
        step();
        n_checks++; if (pc_b !== 32'h4) $display("FAIL post_async got=%h exp=%h", pc_b, 32'h4); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_priority();
        test_ras();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
